// File: rtl/debug_pkg.sv
// Shared types and constants for the debug UART frame transmitter.
// Holds the FSM state encodings, frame geometry and the debug mode tags.
package debug_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Frame-level sequencer states. The bit-level phases live in the byte engine.
   typedef enum logic [1:0] {
      FR_IDLE = 2'd0,
      FR_SEND = 2'd1,
      FR_DONE = 2'd2
   } frame_state_t;

   localparam int         FRAME_BYTES = 5;
   localparam logic [4:0] HEADER_HI   = 5'b10100;

   localparam logic [2:0] MODE_READ_REG  = 3'b000;
   localparam logic [2:0] MODE_WRITE_REG = 3'b001;
   localparam logic [2:0] MODE_READ_MEM  = 3'b010;
   localparam logic [2:0] MODE_WRITE_MEM = 3'b011;
   localparam logic [2:0] MODE_STEP      = 3'b100;
   localparam logic [2:0] MODE_STATUS    = 3'b101;

   function automatic logic [7:0] header_byte(input logic [4:0] hi, input logic [2:0] mode);
      return {hi, mode};
   endfunction

endpackage

// File: rtl/debug_uart_tx_if.sv
// Request/response bundle between the debug controller and the UART frame transmitter.
//
// Handshake: tx_flag is a level request. It is accepted on the rising edge where the
// transmitter is idle and armed; mode/data_internal are sampled on that edge only.
// The controller keeps tx_flag high until doneSending (a one-cycle pulse) is seen.
// busy is high from the cycle after acceptance through the doneSending cycle.
// The transmitter only re-arms after seeing tx_flag low while idle.
interface debug_uart_tx_if;
   logic                  tx_flag;
   logic [2:0]            mode;
   logic [31:0]           data_internal;
   logic                  uart_tx;
   logic                  busy;
   logic                  doneSending;
   debug_pkg::state_t     dbg_state;

   modport master (
      output tx_flag, mode, data_internal,
      input  uart_tx, busy, doneSending, dbg_state
   );

   modport slave (
      input  tx_flag, mode, data_internal,
      output uart_tx, busy, doneSending, dbg_state
   );
endinterface

// File: rtl/uart_byte_tx.sv
// Byte-level 8N1 shifter: start bit, 8 data bits LSB first, stop bit.
// A start request during the last stop-bit cycle chains the next byte with no idle gap.
module uart_byte_tx
   import debug_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       done_o,
   output state_t     state_o
);

   localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   state_t            st_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        bit_q;
   logic [7:0]        sh_q;
   logic              tx_q;
   logic              bit_end;

   assign bit_end = (cnt_q == CNT_LAST);
   // Asserted during the final stop-bit cycle so the caller can chain the next byte.
   assign done_o  = (st_q == ST_STOP) && bit_end;
   assign tx_o    = tx_q;
   assign state_o = st_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q  <= ST_IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         sh_q  <= '0;
         tx_q  <= 1'b1;
      end else begin
         case (st_q)
            ST_IDLE: begin
               cnt_q <= '0;
               tx_q  <= 1'b1;
               if (start_i) begin
                  sh_q  <= data_i;
                  bit_q <= '0;
                  tx_q  <= 1'b0;
                  st_q  <= ST_START;
               end
            end

            ST_START: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  bit_q <= '0;
                  tx_q  <= sh_q[0];
                  sh_q  <= {1'b0, sh_q[7:1]};
                  st_q  <= ST_DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_DATA: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q <= 1'b1;
                     st_q <= ST_STOP;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     tx_q  <= sh_q[0];
                     sh_q  <= {1'b0, sh_q[7:1]};
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_STOP: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (start_i) begin
                     sh_q  <= data_i;
                     bit_q <= '0;
                     tx_q  <= 1'b0;
                     st_q  <= ST_START;
                  end else begin
                     tx_q <= 1'b1;
                     st_q <= ST_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            default: begin
               cnt_q <= '0;
               tx_q  <= 1'b1;
               st_q  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug frame transmitter: sends {HEADER_HI, mode} then data_internal bytes LSB first
// over an 8N1 UART line, one frame per armed request.
module debug_uart_tx #(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [4:0] HEADER_HI    = debug_pkg::HEADER_HI
) (
   input  logic                  CLK,
   input  logic                  RST,
   debug_uart_tx_if.slave        bus
);

   import debug_pkg::*;

   frame_state_t fst_q;
   logic         armed_q;
   logic [31:0]  data_q;
   logic [2:0]   byte_idx_q;
   logic         busy_q;
   logic         done_q;

   logic         capture;
   logic         byte_start;
   logic [7:0]   byte_data;
   logic         byte_done;
   logic         byte_tx;
   state_t       byte_state;

   assign capture = (fst_q == FR_IDLE) && bus.tx_flag && armed_q;

   // The header is built from the live mode input on the capture edge, so the mode
   // is captured straight into the byte shifter rather than a separate register.
   always_comb begin
      byte_start = 1'b0;
      byte_data  = 8'h00;
      if (capture) begin
         byte_start = 1'b1;
         byte_data  = header_byte(HEADER_HI, bus.mode);
      end else if ((fst_q == FR_SEND) && byte_done &&
                   (byte_idx_q < 3'(FRAME_BYTES - 1))) begin
         byte_start = 1'b1;
         byte_data  = data_q[{byte_idx_q[1:0], 3'b000} +: 8];
      end
   end

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .start_i (byte_start),
      .data_i  (byte_data),
      .tx_o    (byte_tx),
      .done_o  (byte_done),
      .state_o (byte_state)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         fst_q      <= FR_IDLE;
         armed_q    <= 1'b0;
         data_q     <= '0;
         byte_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (fst_q)
            FR_IDLE: begin
               byte_idx_q <= '0;
               if (!bus.tx_flag) begin
                  armed_q <= 1'b1;
               end else if (armed_q) begin
                  armed_q <= 1'b0;
                  data_q  <= bus.data_internal;
                  busy_q  <= 1'b1;
                  fst_q   <= FR_SEND;
               end
            end

            FR_SEND: begin
               if (byte_done) begin
                  if (byte_idx_q < 3'(FRAME_BYTES - 1)) begin
                     byte_idx_q <= byte_idx_q + 3'd1;
                  end else begin
                     done_q <= 1'b1;
                     fst_q  <= FR_DONE;
                  end
               end
            end

            FR_DONE: begin
               // A request still held high here leaves armed_q clear, so no repeat frame.
               done_q     <= 1'b0;
               busy_q     <= 1'b0;
               byte_idx_q <= '0;
               fst_q      <= FR_IDLE;
            end

            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               fst_q  <= FR_IDLE;
            end
         endcase
      end
   end

   assign bus.uart_tx     = byte_tx;
   assign bus.busy        = busy_q;
   assign bus.doneSending = done_q;
   assign bus.dbg_state   = (fst_q == FR_IDLE) ? ST_IDLE :
                            (fst_q == FR_DONE) ? ST_DONE : byte_state;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Self-checking bench for debug_uart_tx: random frames compared cycle-by-cycle
// against a bit-stream model, plus reset, re-arm, hold and mid-frame scenarios.
module tb_debug_uart_tx;
   import debug_pkg::*;

   localparam int N         = 4;
   localparam int FRAME_CYC = 50 * N;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   debug_uart_tx_if bus();

   debug_uart_tx #(
      .CLKS_PER_BIT(N),
      .HEADER_HI   (5'b10100)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: line level for each cycle of a frame, from byte list and 8N1 rules.
   function automatic logic [FRAME_CYC-1:0] expected_wave(input logic [2:0] m, input logic [31:0] d);
      logic [7:0]           bytes [5];
      logic [FRAME_CYC-1:0] w;
      int                   bit_no, pos, j;
      bytes[0] = {5'b10100, m};
      for (int k = 1; k < 5; k++) bytes[k] = d[8*(k-1) +: 8];
      for (int c = 0; c < FRAME_CYC; c++) begin
         bit_no = c / N;
         j      = bit_no / 10;
         pos    = bit_no % 10;
         if (pos == 0)      w[c] = 1'b0;
         else if (pos == 9) w[c] = 1'b1;
         else               w[c] = bytes[j][pos-1];
      end
      return w;
   endfunction

   task automatic request(input logic [2:0] m, input logic [31:0] d);
      @(negedge CLK);
      bus.tx_flag = 1'b0;
      @(negedge CLK);
      bus.mode          = m;
      bus.data_internal = d;
      bus.tx_flag       = 1'b1;
   endtask

   // Observes one frame; c = 0 is the first cycle after the capture edge.
   // pert_kind: 0 data -> all ones, 1 drop tx_flag, 2 invert mode, other none.
   task automatic capture_frame(input int pert_cyc, input int pert_kind,
                                output logic [FRAME_CYC-1:0] wave,
                                output int done_cyc, output int busy_low);
      wave     = '1;
      done_cyc = -1;
      busy_low = 0;
      for (int c = 0; c < FRAME_CYC + 20 && done_cyc < 0; c++) begin
         @(negedge CLK);
         if (c < FRAME_CYC) wave[c] = bus.uart_tx;
         if (bus.busy !== 1'b1) busy_low++;
         if (bus.doneSending === 1'b1) done_cyc = c;
         if (c == pert_cyc) begin
            case (pert_kind)
               0:       bus.data_internal = 32'hFFFF_FFFF;
               1:       bus.tx_flag = 1'b0;
               2:       bus.mode = ~bus.mode;
               default: ;
            endcase
         end
      end
   endtask

   task automatic count_activity(input int cycles, output int active);
      active = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge CLK);
         if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0 || bus.doneSending !== 1'b0) active++;
      end
   endtask

   task automatic test_reset();
      bus.tx_flag       = 1'b1;
      bus.mode          = 3'b000;
      bus.data_internal = 32'h0;
      RST               = 1'b0;
      repeat (3) @(negedge CLK);
      n_checks++;
      if (bus.uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx got %b want 1", bus.uart_tx); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_checks++;
      if (bus.doneSending !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.doneSending); end
      n_checks++;
      if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", bus.dbg_state, ST_IDLE); end
   endtask

   task automatic test_no_arm_after_reset();
      logic [FRAME_CYC-1:0] wave, exp_w;
      int done_cyc, busy_low, active;
      @(negedge CLK);
      RST = 1'b1;
      count_activity(40, active);
      n_checks++;
      if (active !== 0) begin n_fail++; $display("FAIL no_arm_activity got %0d active cycles want 0", active); end
      request(MODE_STEP, 32'hA5C3_0F96);
      exp_w = expected_wave(MODE_STEP, 32'hA5C3_0F96);
      capture_frame(-1, 3, wave, done_cyc, busy_low);
      n_checks++;
      if (wave !== exp_w) begin n_fail++; $display("FAIL arm_wave got %h want %h", wave, exp_w); end
      n_checks++;
      if (done_cyc !== FRAME_CYC) begin n_fail++; $display("FAIL arm_done_latency got %0d want %0d", done_cyc, FRAME_CYC); end
   endtask

   task automatic test_basic();
      logic [FRAME_CYC-1:0] wave, exp_w;
      logic [7:0] exp_bytes [5];
      logic [7:0] got;
      int done_cyc, busy_low;
      exp_bytes = '{8'hA1, 8'h78, 8'h56, 8'h34, 8'h12};
      request(3'b001, 32'h1234_5678);
      exp_w = expected_wave(3'b001, 32'h1234_5678);
      capture_frame(-1, 3, wave, done_cyc, busy_low);
      n_checks++;
      if (wave !== exp_w) begin n_fail++; $display("FAIL basic_wave got %h want %h", wave, exp_w); end
      for (int j = 0; j < 5; j++) begin
         for (int i = 0; i < 8; i++) got[i] = wave[(j*10 + 1 + i)*N + N/2];
         n_checks++;
         if (got !== exp_bytes[j]) begin n_fail++; $display("FAIL basic_byte%0d got %h want %h", j, got, exp_bytes[j]); end
      end
      n_checks++;
      if (done_cyc !== FRAME_CYC) begin n_fail++; $display("FAIL basic_done_latency got %0d want %0d", done_cyc, FRAME_CYC); end
      n_checks++;
      if (busy_low !== 0) begin n_fail++; $display("FAIL basic_busy_in_frame got %0d low cycles want 0", busy_low); end
   endtask

   task automatic test_hold();
      int active;
      @(negedge CLK);
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy_after_done got %b want 0", bus.busy); end
      count_activity(500, active);
      n_checks++;
      if (active !== 0) begin n_fail++; $display("FAIL hold_second_frame got %0d active cycles want 0", active); end
   endtask

   task automatic test_data_change();
      logic [FRAME_CYC-1:0] wave, exp_w;
      logic [31:0] d;
      int done_cyc, busy_low;
      d = $urandom & 32'h7FFF_FFFF;
      request(MODE_READ_MEM, d);
      exp_w = expected_wave(MODE_READ_MEM, d);
      capture_frame(20, 0, wave, done_cyc, busy_low);
      n_checks++;
      if (wave !== exp_w) begin n_fail++; $display("FAIL data_change_wave got %h want %h", wave, exp_w); end
      n_checks++;
      if (done_cyc !== FRAME_CYC) begin n_fail++; $display("FAIL data_change_done got %0d want %0d", done_cyc, FRAME_CYC); end
   endtask

   task automatic test_flag_drop();
      logic [FRAME_CYC-1:0] wave, exp_w;
      logic [31:0] d;
      int done_cyc, busy_low, extra;
      d = $urandom;
      request(MODE_STATUS, d);
      exp_w = expected_wave(MODE_STATUS, d);
      capture_frame(10, 1, wave, done_cyc, busy_low);
      n_checks++;
      if (wave !== exp_w) begin n_fail++; $display("FAIL flag_drop_wave got %h want %h", wave, exp_w); end
      n_checks++;
      if (done_cyc !== FRAME_CYC) begin n_fail++; $display("FAIL flag_drop_done got %0d want %0d", done_cyc, FRAME_CYC); end
      extra = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (bus.doneSending === 1'b1) extra++;
      end
      n_checks++;
      if (extra !== 0) begin n_fail++; $display("FAIL flag_drop_done_pulses got %0d extra want 0", extra); end
   endtask

   task automatic test_reset_mid();
      logic [FRAME_CYC-1:0] wave, exp_w;
      int done_cyc, busy_low, active;
      request(MODE_READ_MEM, 32'hCAFE_0000);
      for (int c = 0; c < 90; c++) @(negedge CLK);
      n_checks++;
      if (bus.uart_tx !== 1'b0) begin n_fail++; $display("FAIL pre_reset_line got %b want 0", bus.uart_tx); end
      RST = 1'b0;
      #1;
      n_checks++;
      if (bus.uart_tx !== 1'b1) begin n_fail++; $display("FAIL mid_reset_uart_tx got %b want 1", bus.uart_tx); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %b want 0", bus.busy); end
      @(negedge CLK);
      RST = 1'b1;
      count_activity(10, active);
      n_checks++;
      if (active !== 0) begin n_fail++; $display("FAIL mid_reset_no_restart got %0d active want 0", active); end
      request(MODE_WRITE_MEM, 32'h0BAD_F00D);
      exp_w = expected_wave(MODE_WRITE_MEM, 32'h0BAD_F00D);
      capture_frame(-1, 3, wave, done_cyc, busy_low);
      n_checks++;
      if (wave !== exp_w) begin n_fail++; $display("FAIL after_reset_wave got %h want %h", wave, exp_w); end
      n_checks++;
      if (done_cyc !== FRAME_CYC) begin n_fail++; $display("FAIL after_reset_done got %0d want %0d", done_cyc, FRAME_CYC); end
   endtask

   task automatic test_random();
      logic [FRAME_CYC-1:0] wave, exp_w;
      logic [2:0]  m;
      logic [31:0] d;
      int done_cyc, busy_low, kind, at;
      for (int it = 0; it < 6; it++) begin
         m    = 3'($urandom_range(0, 5));
         d    = $urandom;
         kind = $urandom_range(0, 3);
         at   = $urandom_range(1, 150);
         request(m, d);
         exp_w = expected_wave(m, d);
         capture_frame(at, kind, wave, done_cyc, busy_low);
         n_checks++;
         if (wave !== exp_w) begin n_fail++; $display("FAIL rand%0d_wave got %h want %h", it, wave, exp_w); end
         n_checks++;
         if (done_cyc !== FRAME_CYC) begin n_fail++; $display("FAIL rand%0d_done got %0d want %0d", it, done_cyc, FRAME_CYC); end
         n_checks++;
         if (busy_low !== 0) begin n_fail++; $display("FAIL rand%0d_busy got %0d low cycles want 0", it, busy_low); end
      end
   endtask

   initial begin
      test_reset();
      test_no_arm_after_reset();
      test_basic();
      test_hold();
      test_data_change();
      test_flag_drop();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
